cla16_serial_adder: RTL

// - Multi-word adder: computes WIDTH-bit A+B+cin by streaming 16-bit slices, LSB first, through one CLA16_CLU instance.
// - One slice per clock; registered carry chains the slices.
// - Sits directly around CLA16_CLU: drives its A/B/in operands and consumes its S/Cout each cycle.
// - Used wherever datapaths wider than 16 bits are needed without replicating CLA hardware.

---
 rtl/cla16_serial_adder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cla16_serial_adder.sv
// Multi-word adder: streams WIDTH-bit A+B+cin through one 16-bit carry-lookahead slice, LSB first.
// Optional macro SERIAL_ADDER_SUB_EN adds a sub port (A-B via inverted B and forced carry-in).

module cla16_clu (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  // Carries out of each position of a 4-wide generate/propagate group.
  function automatic logic [3:0] carries4(input logic [3:0] g, input logic [3:0] p, input logic ci);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  logic [15:0] g, p;
  logic [3:0]  gg, pg, gcar, gin, grp_c, bit_c;
  logic [16:0] c;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    gg    = '0;
    pg    = '0;
    grp_c = '0;
    bit_c = '0;
    c     = '0;
    for (int j = 0; j < 4; j++) begin
      grp_c = carries4(g[4*j +: 4], p[4*j +: 4], 1'b0);
      gg[j] = grp_c[3];
      pg[j] = &p[4*j +: 4];
    end
    gcar = carries4(gg, pg, cin);
    gin  = {gcar[2:0], cin};
    c[0] = cin;
    for (int j = 0; j < 4; j++) begin
      bit_c          = carries4(g[4*j +: 4], p[4*j +: 4], gin[j]);
      c[4*j+1 +: 4]  = bit_c;
    end
    s    = p ^ c[15:0];
    cout = c[16];
  end

endmodule

module cla16_serial_adder #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NS = WIDTH / 16;
  localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] bop_lat;
  logic [15:0]      slice_a, slice_b, slice_s;
  logic             slice_c;

  // Current slice operands; B is stored already inverted when subtracting.
  always_comb begin
    slice_a = a_lat[16*int'(cnt) +: 16];
    slice_b = bop_lat[16*int'(cnt) +: 16];
  end

  cla16_clu u_clu (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      carry   <= 1'b0;
      a_lat   <= '0;
      bop_lat <= '0;
      S       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_lat <= A;
`ifdef SERIAL_ADDER_SUB_EN
            bop_lat <= sub ? ~B : B;
            carry   <= sub ? 1'b1 : cin;
`else
            bop_lat <= B;
            carry   <= cin;
`endif
            cnt   <= '0;
            S     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          S[16*int'(cnt) +: 16] <= slice_s;
          carry <= slice_c;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(NS - 1)) begin
            cout  <= slice_c;
            ovf   <= (a_lat[WIDTH-1] == bop_lat[WIDTH-1]) && (slice_s[15] != a_lat[WIDTH-1]);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
